ps2_keyboard_rx: RTL and testbench
==================================

Name: ps2_keyboard_rx

Overview:
- Receives PS/2 keyboard frames on PS2KD/PS2KC and delivers decoded scan-code events to IO.
- Each event carries the base code plus extended (E0) and release (F0) flags.
- Sits directly upstream of IO's keyboard handling; clocked by the divided system clock (clk_half at top level).

Parameters:
- TIMEOUT_CYCLES, 50000, clk cycles without a PS2KC falling edge before a partial frame is aborted.
- FILTER_LEN, 4, consecutive equal synchronized PS2KC samples required to change the filtered clock level.

Ports:
- clk  input  1  system clock.
- reset  input  1  reset.
- PS2KD  input  1  PS/2 data line, asynchronous.
- PS2KC  input  1  PS/2 clock line, asynchronous.
- key_code  output  8  scan code of the last event.
- key_ext  output  1  event was E0-prefixed.
- key_release  output  1  event was F0-prefixed (break).
- key_valid  output  1  one-cycle pulse; key_code/key_ext/key_release are valid during it.
- frame_err  output  1  one-cycle pulse on a parity, stop-bit or timeout error.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high.
- Reset state: all outputs 0; frame FSM in IDLE; filtered clock = 1; shift register, bit counter, timeout counter and prefix flags all 0.
- Synchronizer: two flops on each of PS2KD and PS2KC.
- Clock filter: filtered PS2KC updates only after FILTER_LEN identical consecutive synced samples. A filtered 1->0 transition is a "fall". Each fall samples synced PS2KD.
- Frame FSM:
  - IDLE: a fall with data=0 (start bit) -> DATA, bit count cleared. A fall with data=1 is ignored.
  - DATA: shifts in 8 bits, LSB first. After the 8th bit -> PARITY.
  - PARITY: captures the parity bit -> STOP.
  - STOP: the sampled bit must be 1 and the 8 data bits plus parity must hold an odd count of ones. If so, byte_ready is raised; otherwise frame_err pulses. Either way -> IDLE.
- Timeout: the counter clears on every fall and in IDLE. If it reaches TIMEOUT_CYCLES-1 outside IDLE: FSM -> IDLE, frame_err pulses, the partial byte is discarded.
- Decoder (acts on byte_ready):
  - 0xE0 sets ext_pending; no output.
  - 0xF0 sets brk_pending; no output.
  - Any other byte (including 0xAA, 0xFA, 0xE1) is output as key_code, with key_ext=ext_pending and key_release=brk_pending. key_valid pulses and both pending flags clear.
- Latency: key_valid asserts in the cycle after the cycle in which the stop-bit fall is detected. Total latency from the pin edge = 2 sync + FILTER_LEN + 2 cycles.
- key_code, key_ext and key_release hold their values until the next key_valid.
- frame_err also clears both pending flags. frame_err and key_valid are never asserted in the same cycle.
- A fall arriving in the same cycle the timeout fires: the timeout wins and that fall is dropped.
- Reset asserted mid-frame: immediate return to the reset state; the next complete frame decodes normally.

Decomposition:
- Package ps2_pkg:
  - frame FSM state encoding (IDLE, DATA, PARITY, STOP);
  - constants PS2_EXT=8'hE0 and PS2_BRK=8'hF0.
- Sub-module ps2_frame_rx: synchronizer, filter, frame FSM and timeout. Outputs byte[7:0], byte_ready and frame_err.
- ps2_keyboard_rx instantiates ps2_frame_rx and contains the prefix decoder and output registers.

Test Plan:
- Bench settings: TIMEOUT_CYCLES=500, FILTER_LEN=4, PS2KC half-period 40 cycles, data changed mid-high.
- Single key: frame 0x1C, parity 0, stop 1 -> one key_valid pulse with key_code=0x1C, key_ext=0, key_release=0; frame_err stays 0.
- Break and extended sequences:
  - F0,1C -> exactly one pulse: 0x1C, release=1, ext=0.
  - E0,F0,75 -> one pulse: 0x75, ext=1, release=1.
  - E0,6B -> 0x6B, ext=1, release=0.
- Parity and stop errors:
  - 0x1C sent with parity 1 -> frame_err pulse, no key_valid.
  - F0, then a bad-stop frame, then 0x1C -> key_code 0x1C with release=0 (flags cleared by the error).
- Timeout: stop PS2KC after 5 data bits -> frame_err pulse exactly 500 cycles after the last fall; a following 0x29 frame decodes as 0x29, flags 0.
- Glitch: a 2-cycle low pulse on PS2KC, both in IDLE and mid-DATA -> no extra bit; the frame 0x5A still decodes as 0x5A.
- Reset mid-frame: assert reset after 4 bits -> all outputs 0 immediately; after release, 0x1C decodes correctly.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
package ps2_pkg;

  // Frame receiver state: start bit seen -> 8 data bits -> parity -> stop.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } frame_state_e;

  // Scan-code prefixes that modify the following code rather than emit an event.
  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 byte receiver: input synchronizers, clock glitch filter, frame FSM, timeout.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter int unsigned FILTER_LEN     = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_kd,
  input  logic       ps2_kc,
  output logic [7:0] rx_byte,
  output logic       byte_ready,
  output logic       frame_err
);

  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES);
  localparam int unsigned FL_W = $clog2(FILTER_LEN + 1);

  logic            kd_s1_q, kd_s2_q, kc_s1_q, kc_s2_q;
  logic [FL_W-1:0] flt_cnt_q, flt_cnt_d;
  logic            kc_flt_q, kc_flt_d;
  logic            fall_q, fall_d;
  logic            kd_bit_q, kd_bit_d;
  frame_state_e    state_q, state_d;
  logic [7:0]      shift_q, shift_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic            par_q, par_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic [7:0]      rx_byte_q, rx_byte_d;
  logic            byte_ready_q, byte_ready_d;
  logic            frame_err_q, frame_err_d;

  // Filter: the filtered clock follows the synced line only after FILTER_LEN
  // consecutive disagreeing samples; data is captured at the same instant.
  always_comb begin
    flt_cnt_d = flt_cnt_q;
    kc_flt_d  = kc_flt_q;
    fall_d    = 1'b0;
    kd_bit_d  = kd_bit_q;
    if (kc_s2_q == kc_flt_q) begin
      flt_cnt_d = '0;
    end else if (flt_cnt_q == FL_W'(FILTER_LEN - 1)) begin
      flt_cnt_d = '0;
      kc_flt_d  = kc_s2_q;
      fall_d    = ~kc_s2_q;
      kd_bit_d  = kd_s2_q;
    end else begin
      flt_cnt_d = flt_cnt_q + FL_W'(1);
    end
  end

  // Frame FSM next state; a timeout outranks a fall arriving in the same cycle.
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    par_d        = par_q;
    rx_byte_d    = rx_byte_q;
    byte_ready_d = 1'b0;
    frame_err_d  = 1'b0;
    to_cnt_d     = (state_q == IDLE) ? '0 : to_cnt_q + TO_W'(1);
    if (state_q != IDLE && to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
      state_d     = IDLE;
      frame_err_d = 1'b1;
      to_cnt_d    = '0;
      bit_cnt_d   = '0;
      shift_d     = '0;
    end else if (fall_q) begin
      to_cnt_d = '0;
      case (state_q)
        IDLE: begin
          if (!kd_bit_q) begin
            state_d   = DATA;
            bit_cnt_d = '0;
          end
        end
        DATA: begin
          shift_d   = {kd_bit_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          par_d   = kd_bit_q;
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (kd_bit_q && (^{shift_q, par_q})) begin
            byte_ready_d = 1'b1;
            rx_byte_d    = shift_q;
          end else begin
            frame_err_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State registers; lines idle high so synchronizers reset to 1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      kd_s1_q      <= 1'b1;
      kd_s2_q      <= 1'b1;
      kc_s1_q      <= 1'b1;
      kc_s2_q      <= 1'b1;
      flt_cnt_q    <= '0;
      kc_flt_q     <= 1'b1;
      fall_q       <= 1'b0;
      kd_bit_q     <= 1'b0;
      state_q      <= IDLE;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      par_q        <= 1'b0;
      to_cnt_q     <= '0;
      rx_byte_q    <= '0;
      byte_ready_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      kd_s1_q      <= ps2_kd;
      kd_s2_q      <= kd_s1_q;
      kc_s1_q      <= ps2_kc;
      kc_s2_q      <= kc_s1_q;
      flt_cnt_q    <= flt_cnt_d;
      kc_flt_q     <= kc_flt_d;
      fall_q       <= fall_d;
      kd_bit_q     <= kd_bit_d;
      state_q      <= state_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      par_q        <= par_d;
      to_cnt_q     <= to_cnt_d;
      rx_byte_q    <= rx_byte_d;
      byte_ready_q <= byte_ready_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign rx_byte    = rx_byte_q;
  assign byte_ready = byte_ready_q;
  assign frame_err  = frame_err_q;

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: byte reception plus E0/F0 prefix decoding into key events.
module ps2_keyboard_rx
  import ps2_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter int unsigned FILTER_LEN     = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       PS2KD,
  input  logic       PS2KC,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_release,
  output logic       key_valid,
  output logic       frame_err
);

  logic [7:0] rx_byte_w;
  logic       byte_ready_w;
  logic       frame_err_w;

  logic [7:0] key_code_q, key_code_d;
  logic       key_ext_q, key_ext_d;
  logic       key_release_q, key_release_d;
  logic       key_valid_q, key_valid_d;
  logic       ext_pend_q, ext_pend_d;
  logic       brk_pend_q, brk_pend_d;

  ps2_frame_rx #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .FILTER_LEN    (FILTER_LEN)
  ) u_frame (
    .clk       (clk),
    .reset     (reset),
    .ps2_kd    (PS2KD),
    .ps2_kc    (PS2KC),
    .rx_byte   (rx_byte_w),
    .byte_ready(byte_ready_w),
    .frame_err (frame_err_w)
  );

  // Prefix decoder: E0/F0 arm flags, any other byte emits an event; errors drop prefixes.
  always_comb begin
    key_code_d    = key_code_q;
    key_ext_d     = key_ext_q;
    key_release_d = key_release_q;
    key_valid_d   = 1'b0;
    ext_pend_d    = ext_pend_q;
    brk_pend_d    = brk_pend_q;
    if (frame_err_w) begin
      ext_pend_d = 1'b0;
      brk_pend_d = 1'b0;
    end else if (byte_ready_w) begin
      if (rx_byte_w == PS2_EXT) begin
        ext_pend_d = 1'b1;
      end else if (rx_byte_w == PS2_BRK) begin
        brk_pend_d = 1'b1;
      end else begin
        key_code_d    = rx_byte_w;
        key_ext_d     = ext_pend_q;
        key_release_d = brk_pend_q;
        key_valid_d   = 1'b1;
        ext_pend_d    = 1'b0;
        brk_pend_d    = 1'b0;
      end
    end
  end

  // Output and prefix-flag registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_code_q    <= '0;
      key_ext_q     <= 1'b0;
      key_release_q <= 1'b0;
      key_valid_q   <= 1'b0;
      ext_pend_q    <= 1'b0;
      brk_pend_q    <= 1'b0;
    end else begin
      key_code_q    <= key_code_d;
      key_ext_q     <= key_ext_d;
      key_release_q <= key_release_d;
      key_valid_q   <= key_valid_d;
      ext_pend_q    <= ext_pend_d;
      brk_pend_q    <= brk_pend_d;
    end
  end

  assign key_code    = key_code_q;
  assign key_ext     = key_ext_q;
  assign key_release = key_release_q;
  assign key_valid   = key_valid_q;
  assign frame_err   = frame_err_w;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Scoreboard bench for ps2_keyboard_rx: directed frames, expected events queued.
module tb_ps2_keyboard_rx;

  localparam int unsigned TO   = 500;
  localparam int unsigned FL   = 4;
  localparam int unsigned HALF = 40;
  // Pin fall -> frame_err: 2 sync + FL filter + 1 FSM edge, then TO counting cycles.
  localparam int TO_LAT = 2 + FL + 1 + TO;

  typedef struct packed {
    logic       is_err;
    logic [7:0] code;
    logic       ext;
    logic       rel;
  } ev_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       ps2kd;
  logic       ps2kc;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_release;
  logic       key_valid;
  logic       frame_err;

  int  tests = 0;
  int  fails = 0;
  int  cyc = 0;
  int  last_fall_cyc = 0;
  int  err_cyc = -100000;
  ev_t sb[$];

  ps2_keyboard_rx #(
    .TIMEOUT_CYCLES(TO),
    .FILTER_LEN    (FL)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .PS2KD      (ps2kd),
    .PS2KC      (ps2kc),
    .key_code   (key_code),
    .key_ext    (key_ext),
    .key_release(key_release),
    .key_valid  (key_valid),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_key(input logic [7:0] c, input logic e, input logic r);
    ev_t ev;
    ev.is_err = 1'b0; ev.code = c; ev.ext = e; ev.rel = r;
    sb.push_back(ev);
  endtask

  task automatic push_err();
    ev_t ev;
    ev.is_err = 1'b1; ev.code = 8'h00; ev.ext = 1'b0; ev.rel = 1'b0;
    sb.push_back(ev);
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic bad_par,
                                           input logic bad_stop);
    return {~bad_stop, (~(^d)) ^ bad_par, d, 1'b0};
  endfunction

  // One PS/2 bit: high half (data changes mid-high, optional 2-cycle glitch), then low half.
  task automatic drive_bit(input logic b, input logic glitch);
    if (glitch) begin
      wait_neg(10); ps2kc = 1'b0; wait_neg(2); ps2kc = 1'b1; wait_neg(8);
    end else begin
      wait_neg(HALF / 2);
    end
    ps2kd = b;
    wait_neg(HALF / 2);
    ps2kc = 1'b0;
    last_fall_cyc = cyc;
    wait_neg(HALF);
    ps2kc = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic bad_stop,
                            input int glitch_bit, input int nbits);
    logic [10:0] f;
    f = mk_frame(d, bad_par, bad_stop);
    for (int i = 0; i < nbits; i++) drive_bit(f[i], i == glitch_bit);
    ps2kd = 1'b1;
    wait_neg(100);
  endtask

  task automatic send(input logic [7:0] d);
    send_frame(d, 1'b0, 1'b0, -1, 11);
  endtask

  // Monitor: every key_valid / frame_err pulse is matched against the queue head.
  always @(negedge clk) begin
    ev_t e;
    if (!reset && (key_valid || frame_err)) begin
      if (frame_err) err_cyc = cyc;
      if (key_valid && frame_err) begin
        tests++; fails++;
        $display("FAIL both_pulses: key_valid and frame_err high together");
      end
      if (sb.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_event: valid=%0b err=%0b code=0x%0h", key_valid, frame_err,
                 key_code);
      end else begin
        e = sb.pop_front();
        tests++;
        if (e.is_err != frame_err ||
            (!e.is_err && {key_code, key_ext, key_release} != {e.code, e.ext, e.rel})) begin
          fails++;
          $display("FAIL event: got err=%0b code=0x%0h ext=%0b rel=%0b expected err=%0b code=0x%0h ext=%0b rel=%0b",
                   frame_err, key_code, key_ext, key_release, e.is_err, e.code, e.ext, e.rel);
        end
      end
    end
  end

  initial begin
    reset = 1'b1; ps2kd = 1'b1; ps2kc = 1'b1;
    wait_neg(5);
    check("rst_key_code", 32'(key_code), 32'h0);
    check("rst_key_ext", 32'(key_ext), 32'h0);
    check("rst_key_release", 32'(key_release), 32'h0);
    check("rst_key_valid", 32'(key_valid), 32'h0);
    check("rst_frame_err", 32'(frame_err), 32'h0);
    reset = 1'b0;
    wait_neg(20);

    // Plain make code
    push_key(8'h1C, 1'b0, 1'b0);
    send(8'h1C);

    // Break, extended break, extended make
    push_key(8'h1C, 1'b0, 1'b1);
    send(8'hF0); send(8'h1C);
    push_key(8'h75, 1'b1, 1'b1);
    send(8'hE0); send(8'hF0); send(8'h75);
    push_key(8'h6B, 1'b1, 1'b0);
    send(8'hE0); send(8'h6B);

    // Parity error: no key event, outputs hold
    push_err();
    send_frame(8'h1C, 1'b1, 1'b0, -1, 11);
    check("hold_key_code", 32'(key_code), 32'h6B);

    // Bad stop after F0 clears the pending break
    push_err();
    push_key(8'h1C, 1'b0, 1'b0);
    send(8'hF0);
    send_frame(8'h1C, 1'b0, 1'b1, -1, 11);
    send(8'h1C);

    // Timeout after start + 5 data bits
    push_err();
    push_key(8'h29, 1'b0, 1'b0);
    send_frame(8'h29, 1'b0, 1'b0, -1, 6);
    wait_neg(TO + 50);
    check("timeout_latency", 32'(err_cyc - last_fall_cyc), 32'(TO_LAT));
    send(8'h29);

    // Glitches in IDLE and mid-DATA
    ps2kc = 1'b0; wait_neg(2); ps2kc = 1'b1;
    wait_neg(30);
    push_key(8'h5A, 1'b0, 1'b0);
    send_frame(8'h5A, 1'b0, 1'b0, 4, 11);

    // Reset after 4 bits of a frame
    send_frame(8'h1C, 1'b0, 1'b0, -1, 4);
    reset = 1'b1;
    #1;
    check("midrst_key_code", 32'(key_code), 32'h0);
    check("midrst_key_ext", 32'(key_ext), 32'h0);
    check("midrst_key_release", 32'(key_release), 32'h0);
    check("midrst_key_valid", 32'(key_valid), 32'h0);
    check("midrst_frame_err", 32'(frame_err), 32'h0);
    ps2kc = 1'b1; ps2kd = 1'b1;
    wait_neg(5);
    reset = 1'b0;
    wait_neg(20);
    push_key(8'h1C, 1'b0, 1'b0);
    send(8'h1C);

    wait_neg(200);
    check("scoreboard_drained", 32'(sb.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
